spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Converts a spike train back into an 8-bit rate value. It is the decode end of the rate-coded link whose encode end is the integrate-and-fire neuron, which accumulates an 8-bit input and fires at threshold 128. The block counts spikes over a fixed window of 2^WINDOW_LOG2 cycles and presents the count through a valid/ready output register. Placement: downstream of neuron spike outputs, feeding readout or next-layer logic.

Parameters:
WINDOW_LOG2, 7, window length = 2^WINDOW_LOG2 cycles. Default 128 matches the neuron threshold, so a constant neuron input v yields about v spikes per window.
OUT_W, 8, width of rate_value; the count saturates at 2^OUT_W-1.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
enable  in  1  1 = run back-to-back windows; 0 = abort and idle.
spike_in  in  1  spike input, sampled every cycle in COUNT.
rate_value  out  OUT_W  latched window count.
rate_valid  out  1  rate_value holds an unconsumed result.
rate_ready  in  1  consumer accepts when rate_valid & rate_ready.
overrun  out  1  one-cycle pulse: an unconsumed result was overwritten.
busy  out  1  1 while in COUNT.

Behaviour:
- Reset: sampled only on a clk edge. All outputs are 0 afterwards: rate_value=0, rate_valid=0, overrun=0, busy=0. State goes to IDLE, wcnt=0, scnt=0. Reset mid-window discards the partial count and any pending result.
- Internal counters:
  - wcnt: WINDOW_LOG2 bits, counts cycles within the window.
  - scnt: WINDOW_LOG2+1 bits, counts spikes; its maximum is 2^WINDOW_LOG2, so it never wraps.
- States:
  - IDLE: enable=1 → COUNT, with wcnt and scnt cleared. Spikes are not counted in the IDLE cycle.
  - COUNT, enable=0: → IDLE. The partial window is discarded. rate_value and rate_valid are untouched.
  - COUNT, enable=1, wcnt<2^WINDOW_LOG2-1: wcnt+=1, scnt+=spike_in.
  - COUNT, enable=1, wcnt=2^WINDOW_LOG2-1 (last cycle): final = scnt+spike_in, so the last-cycle spike is counted. Next edge: rate_value = min(final, 2^OUT_W-1), rate_valid=1, wcnt=0, scnt=0. Stays in COUNT; windows run back-to-back with no gap cycle.
- Latency: the result is visible the cycle after the last window cycle. The first window after enable completes 2^WINDOW_LOG2+1 edges after enable is first sampled high.
- Handshake:
  - rate_valid falls on the edge after a cycle with rate_valid & rate_ready, unless a new result loads on that same edge.
  - Accept and load on the same edge: new value loaded, rate_valid stays 1, no overrun.
  - Load while rate_valid=1 and rate_ready=0: new value overwrites, rate_valid stays 1, overrun=1 for exactly that one cycle.
  - rate_value is stable whenever rate_valid=1 and no load occurs.
- Spike every cycle with defaults: final=128, rate_value=128. Saturation only applies when 2^WINDOW_LOG2 > 2^OUT_W-1.

Optional Feature:
Macro SPIKE_RATE_DECODER_EMA_EN.
- Defined: a smoothing register ema (OUT_W bits) is kept.
  - First load after reset: ema = sat(final).
  - Later loads: ema = (ema + sat(final)) >> 1, computed in OUT_W+1 bits and truncating.
  - rate_value = ema.
  - ema is cleared only by rst, not by enable dropping.
- Not defined: rate_value = sat(final) directly; no ema register exists.

Decomposition:
- Shared package snn_pkg:
  - state enum type (IDLE, COUNT);
  - default constants SNN_WINDOW_LOG2=7 and SNN_RATE_W=8, shared with the neuron threshold definition.
- One natural sub-module, spike_window_timer:
  - contents: wcnt plus a last-cycle flag (window_last), with clear and advance inputs.
  - it is reused by future windowed SNN blocks.
- Decoder FSM, spike counter and output register stay in spike_rate_decoder.

Test Plan:
- enable=1, spike_in=1 every cycle, rate_ready=1 → after 129 edges: rate_valid=1, rate_value=128, overrun=0.
- spike_in=1 every 4th cycle (as produced by a neuron with input 32) for 3 windows, rate_ready=1 → three results of 32, 128 cycles apart, no gaps.
- rate_ready=0, two windows of 10 then 20 spikes → first result rate_value=10; at the second load overrun pulses 1 cycle and rate_value=20. Then rate_ready=1 → rate_valid drops the next edge.
- Pulse rate_ready exactly on the load edge with 5 then 7 spikes → value 7 loaded, rate_valid stays 1, no overrun.
- enable drops at window cycle 50 after 12 spikes → IDLE, busy=0, no result. Re-enable → a fresh full window counts from 0.
- rst asserted mid-window with a pending result → next cycle all outputs 0. With EMA_EN, windows of 100 then 50 → rate_value 100, then 75.

Source files
------------

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared state type and default widths for windowed SNN blocks
package snn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } snn_state_t;

    // Same values the neuron threshold is derived from (threshold = 2^SNN_WINDOW_LOG2)
    localparam int SNN_WINDOW_LOG2 = 7;
    localparam int SNN_RATE_W      = 8;

endpackage

// File: rtl/spike_window_timer.sv
// rtl/spike_window_timer.sv - free-running window cycle counter with last-cycle flag
module spike_window_timer
    import snn_pkg::*;
#(
    parameter int WINDOW_LOG2 = SNN_WINDOW_LOG2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic window_last
);

    logic [WINDOW_LOG2-1:0] wcnt;

    // Advancing past the last cycle wraps to 0, which starts the next window
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wcnt <= '0;
        end else if (advance) begin
            wcnt <= wcnt + WINDOW_LOG2'(1);
        end
    end

    assign window_last = (wcnt == {WINDOW_LOG2{1'b1}});

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike counter with valid/ready rate output
// Optional smoothing of the output enabled by SPIKE_RATE_DECODER_EMA_EN.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int WINDOW_LOG2 = SNN_WINDOW_LOG2,
    parameter int OUT_W       = SNN_RATE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    output logic [OUT_W-1:0] rate_value,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int          CNT_W    = WINDOW_LOG2 + 1;
    localparam logic [31:0] RATE_MAX = (32'd1 << OUT_W) - 32'd1;

    snn_state_t       state;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] final_cnt;
    logic [31:0]      final_ext;
    logic [OUT_W-1:0] sat_cnt;
    logic [OUT_W-1:0] load_value;
    logic             window_last;
    logic             timer_clear;
    logic             timer_advance;
    logic             load;

    assign timer_clear   = (state == IDLE) || !enable;
    assign timer_advance = (state == COUNT) && enable;
    assign load          = timer_advance && window_last;

    spike_window_timer #(
        .WINDOW_LOG2(WINDOW_LOG2)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clear),
        .advance    (timer_advance),
        .window_last(window_last)
    );

    // The spike of the current cycle is folded in so the last-cycle spike is not lost
    assign final_cnt = scnt + CNT_W'(spike_in);
    assign final_ext = 32'(final_cnt);
    assign sat_cnt   = (final_ext > RATE_MAX) ? RATE_MAX[OUT_W-1:0] : final_ext[OUT_W-1:0];

`ifdef SPIKE_RATE_DECODER_EMA_EN
    // rate_value doubles as the ema register; only rst clears it
    logic           ema_seen;
    logic [OUT_W:0] ema_sum;

    assign ema_sum    = {1'b0, rate_value} + {1'b0, sat_cnt};
    assign load_value = ema_seen ? ema_sum[OUT_W:1] : sat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ema_seen <= 1'b0;
        end else if (load) begin
            ema_seen <= 1'b1;
        end
    end
`else
    assign load_value = sat_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            scnt       <= '0;
            rate_value <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rate_valid && rate_ready) begin
                rate_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                        scnt  <= '0;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        scnt  <= '0;
                    end else if (window_last) begin
                        scnt       <= '0;
                        rate_value <= load_value;
                        rate_valid <= 1'b1;
                        overrun    <= rate_valid && !rate_ready;
                    end else begin
                        scnt <= final_cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - randomized self-checking bench for spike_rate_decoder
module tb_spike_rate_decoder;

    localparam int WIN = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       spike_in;
    logic [7:0] rate_value;
    logic       rate_valid;
    logic       rate_ready;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int ema_m      = 0;
    bit ema_seen_m = 0;

    spike_rate_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .spike_in  (spike_in),
        .rate_value(rate_value),
        .rate_valid(rate_valid),
        .rate_ready(rate_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected rate_value after a window holding n spikes
    function automatic int model_load(input int n);
        int s;
        s = (n > 255) ? 255 : n;
`ifdef SPIKE_RATE_DECODER_EMA_EN
        if (ema_seen_m) ema_m = (ema_m + s) / 2;
        else ema_m = s;
        ema_seen_m = 1;
        return ema_m;
`else
        return s;
`endif
    endfunction

    function automatic logic [WIN-1:0] gen_pattern(input int n, input int limit);
        logic [WIN-1:0] p;
        int k;
        int pos;
        p = '0;
        k = 0;
        while (k < n) begin
            pos = $urandom_range(limit - 1, 0);
            if (!p[pos]) begin
                p[pos] = 1'b1;
                k++;
            end
        end
        return p;
    endfunction

    function automatic int popcount(input logic [WIN-1:0] p);
        int c = 0;
        for (int i = 0; i < WIN; i++) c += int'(p[i]);
        return c;
    endfunction

    // Drives one full window; reports what was observed on the outputs during it
    task automatic run_window(input logic [WIN-1:0] pat, input bit ready_pulse,
                              output int ovr_cnt, output int valid_cnt,
                              output int first_valid, output int changes);
        logic [7:0] prev;
        ovr_cnt = 0;
        valid_cnt = 0;
        first_valid = -1;
        changes = 0;
        prev = rate_value;
        for (int i = 0; i < WIN; i++) begin
            spike_in = pat[i];
            if (ready_pulse) rate_ready = (i == WIN - 1);
            step();
            if (overrun) ovr_cnt++;
            if (rate_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = i;
            end
            if (i != WIN - 1 && rate_value !== prev) changes++;
            prev = rate_value;
        end
        if (ready_pulse) rate_ready = 1'b0;
        spike_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; spike_in = 1'b0; rate_ready = 1'b0;
        step(); step();
        ema_m = 0; ema_seen_m = 0;
        checks++; if (rate_value !== 8'd0) begin errors++; $display("FAIL reset_value got=%0d exp=0", rate_value); end
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rate_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_rate();
        int o, v, f, c, exp;
        rate_ready = 1'b1;
        enable = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got=%b exp=1", busy); end
        run_window({WIN{1'b1}}, 1'b0, o, v, f, c);
        exp = model_load(WIN);
        checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", rate_valid); end
        checks++; if (rate_value !== 8'(exp)) begin errors++; $display("FAIL full_value got=%0d exp=%0d", rate_value, exp); end
        checks++; if (o != 0) begin errors++; $display("FAIL full_overrun got=%0d exp=0", o); end
        checks++; if (f != WIN - 1) begin errors++; $display("FAIL full_latency got=%0d exp=%0d", f, WIN - 1); end
        enable = 1'b0;
        step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL full_accept got=%b exp=0", rate_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_quarter_rate();
        logic [WIN-1:0] pat;
        int o, v, f, c, exp;
        for (int i = 0; i < WIN; i++) pat[i] = ((i % 4) == 3);
        rate_ready = 1'b1;
        enable = 1'b1;
        step();
        for (int w = 0; w < 3; w++) begin
            run_window(pat, 1'b0, o, v, f, c);
            exp = model_load(32);
            checks++; if (rate_value !== 8'(exp)) begin errors++; $display("FAIL quarter_value w=%0d got=%0d exp=%0d", w, rate_value, exp); end
            checks++; if (v != 1 || f != WIN - 1) begin errors++; $display("FAIL quarter_spacing w=%0d got=%0d/%0d exp=1/%0d", w, v, f, WIN - 1); end
            checks++; if (o != 0) begin errors++; $display("FAIL quarter_overrun w=%0d got=%0d exp=0", w, o); end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_overrun();
        int o, v, f, c, exp;
        rate_ready = 1'b0;
        enable = 1'b1;
        step();
        run_window(gen_pattern(10, WIN), 1'b0, o, v, f, c);
        exp = model_load(10);
        checks++; if (rate_value !== 8'(exp) || rate_valid !== 1'b1) begin errors++; $display("FAIL ovr_first got=%0d/%b exp=%0d/1", rate_value, rate_valid, exp); end
        checks++; if (o != 0) begin errors++; $display("FAIL ovr_first_pulse got=%0d exp=0", o); end
        run_window(gen_pattern(20, WIN), 1'b0, o, v, f, c);
        checks++; if (c != 0) begin errors++; $display("FAIL ovr_stable got=%0d changes exp=0", c); end
        exp = model_load(20);
        checks++; if (rate_value !== 8'(exp) || rate_valid !== 1'b1) begin errors++; $display("FAIL ovr_second got=%0d/%b exp=%0d/1", rate_value, rate_valid, exp); end
        checks++; if (o != 1 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got=%0d/%b exp=1/1", o, overrun); end
        enable = 1'b0;
        rate_ready = 1'b1;
        step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", rate_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle got=%b exp=0", overrun); end
    endtask

    task automatic test_same_edge_accept();
        int o, v, f, c, exp;
        rate_ready = 1'b0;
        enable = 1'b1;
        step();
        run_window(gen_pattern(5, WIN), 1'b0, o, v, f, c);
        exp = model_load(5);
        checks++; if (rate_value !== 8'(exp)) begin errors++; $display("FAIL same_first got=%0d exp=%0d", rate_value, exp); end
        run_window(gen_pattern(7, WIN), 1'b1, o, v, f, c);
        exp = model_load(7);
        checks++; if (rate_value !== 8'(exp) || rate_valid !== 1'b1) begin errors++; $display("FAIL same_load got=%0d/%b exp=%0d/1", rate_value, rate_valid, exp); end
        checks++; if (o != 0) begin errors++; $display("FAIL same_overrun got=%0d exp=0", o); end
        enable = 1'b0;
        rate_ready = 1'b1;
        step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL same_drain got=%b exp=0", rate_valid); end
    endtask

    task automatic test_abort();
        logic [WIN-1:0] part;
        int o, v, f, c, exp, n;
        bit bad;
        part = gen_pattern(12, 50);
        rate_ready = 1'b1;
        enable = 1'b1;
        step();
        for (int i = 0; i < 50; i++) begin
            spike_in = part[i];
            step();
        end
        spike_in = 1'b0;
        enable = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || rate_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b/%b exp=0/0", busy, rate_valid); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            spike_in = 1'($urandom_range(1, 0));
            step();
            if (busy !== 1'b0 || rate_valid !== 1'b0) bad = 1;
        end
        spike_in = 1'b0;
        checks++; if (bad) begin errors++; $display("FAIL abort_quiet got=1 exp=0"); end
        n = $urandom_range(60, 1);
        enable = 1'b1;
        step();
        run_window(gen_pattern(n, WIN), 1'b0, o, v, f, c);
        exp = model_load(n);
        checks++; if (rate_value !== 8'(exp) || v != 1) begin errors++; $display("FAIL abort_fresh got=%0d/%0d exp=%0d/1", rate_value, v, exp); end
        enable = 1'b0;
        step();
    endtask

    task automatic test_random_windows();
        logic [WIN-1:0] pat;
        int o, v, f, c, exp, n;
        rate_ready = 1'b1;
        enable = 1'b1;
        step();
        for (int w = 0; w < 6; w++) begin
            n = (w == 0) ? 0 : $urandom_range(WIN, 1);
            pat = gen_pattern(n, WIN);
            run_window(pat, 1'b0, o, v, f, c);
            exp = model_load(popcount(pat));
            checks++; if (rate_value !== 8'(exp)) begin errors++; $display("FAIL rand_value w=%0d got=%0d exp=%0d", w, rate_value, exp); end
            checks++; if (v != 1 || o != 0) begin errors++; $display("FAIL rand_handshake w=%0d got=%0d/%0d exp=1/0", w, v, o); end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int o, v, f, c, exp, exp2;
        rate_ready = 1'b0;
        enable = 1'b1;
        step();
        run_window(gen_pattern(40, WIN), 1'b0, o, v, f, c);
        exp = model_load(40);
        for (int i = 0; i < 30; i++) begin
            spike_in = 1'($urandom_range(1, 0));
            step();
        end
        spike_in = 1'b0;
        rst = 1'b1;
        step();
        ema_m = 0; ema_seen_m = 0;
        checks++; if (rate_value !== 8'd0 || rate_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out got=%0d/%b exp=0/0", rate_value, rate_valid); end
        checks++; if (overrun !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b/%b exp=0/0", overrun, busy); end
        rst = 1'b0;
        rate_ready = 1'b1;
        step();
        run_window(gen_pattern(100, WIN), 1'b0, o, v, f, c);
        exp = model_load(100);
        checks++; if (rate_value !== 8'(exp) || rate_value !== 8'd100) begin errors++; $display("FAIL rstmid_w1 got=%0d exp=%0d", rate_value, exp); end
        run_window(gen_pattern(50, WIN), 1'b0, o, v, f, c);
        exp = model_load(50);
`ifdef SPIKE_RATE_DECODER_EMA_EN
        exp2 = 75;
`else
        exp2 = 50;
`endif
        checks++; if (rate_value !== 8'(exp) || rate_value !== 8'(exp2)) begin errors++; $display("FAIL rstmid_w2 got=%0d exp=%0d", rate_value, exp2); end
        enable = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_quarter_rate();
        test_overrun();
        test_same_edge_accept();
        test_abort();
        test_random_windows();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
